instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Instruction fetch sequencer for the OSECPU core.
- Reads 32-bit words from instruction memory over a req/ack handshake.
- Assembles one- or two-word instructions and drives `instr0`, `instr1` and `current_state` into the datapath.
- Steps the 4-bit state machine: HLT -> FETCH0 -> (FETCH1) -> EXEC -> FETCH0 ... until an END opcode, an external halt, or a bus timeout.

Parameters:
- `PC_W`, 16, program counter / instruction address width.
- `OP_LIMM32`, 8'h03, opcode (`instr0[31:24]`) of the two-word instruction; its second word is the immediate.
- `OP_END`, 8'hFF, opcode that stops execution after its EXEC cycle.
- `TIMEOUT`, 255, max cycles waiting for `imem_ack` before error; 8-bit counter.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  1-cycle pulse; begin fetching at `start_pc` (honoured only in HLT)
- `start_pc`  in  PC_W  entry address
- `halt_req`  in  1  level; stop at next instruction boundary
- `pc_load`  in  1  1-cycle pulse, valid only during EXEC; redirect next fetch
- `pc_load_val`  in  PC_W  redirect target
- `imem_req`  out  1  read request
- `imem_addr`  out  PC_W  word address
- `imem_ack`  in  1  read data valid, 1 cycle
- `imem_data`  in  32  read data
- `instr0`  out  32  first instruction word
- `instr1`  out  32  second word (LIMM32 immediate), else 0
- `current_state`  out  4  state code
- `pc`  out  PC_W  address of the next word to fetch
- `busy`  out  1  1 when state != HLT
- `bus_err`  out  1  sticky; set on ack timeout, cleared by `start`

Behaviour:
- State codes (def.v): `STATE_HLT`=0, `STATE_FETCH0`=1, `STATE_FETCH1`=2, `STATE_EXEC`=3, `STATE_ERR`=4.
- Reset (async) values:
  - `current_state`=HLT.
  - `pc`, `instr0`, `instr1`, `imem_addr` = 0.
  - `imem_req`, `bus_err` = 0.
  - Timeout counter = 0.
  - `busy` is combinational from state.
  - Reset mid-transaction abandons it; a late `imem_ack` in HLT is ignored.
- HLT:
  - On `start`: `pc`<=`start_pc`, `bus_err`<=0, go to FETCH0.
  - `start` in any other state is ignored.
- FETCH0:
  - `imem_req`=1 and `imem_addr`=`pc`, registered; both held stable until ack.
  - Request is issued on the first FETCH0 cycle.
  - On `imem_ack`:
    - `instr0`<=`imem_data`, `pc`<=`pc`+1 (wraps modulo 2^PC_W), `imem_req`<=0.
    - If `imem_data[31:24]`==`OP_LIMM32`, go to FETCH1.
    - Else `instr1`<=0 and go to EXEC.
  - Ack arriving on the same cycle that `imem_req` first rises is accepted.
- FETCH1:
  - Same handshake at the new `pc`.
  - On ack: `instr1`<=`imem_data`, `pc`<=`pc`+1, go to EXEC.
- Timeout (FETCH0/FETCH1):
  - Counter increments each cycle `req`=1 without ack; resets on ack.
  - On reaching `TIMEOUT`: `bus_err`<=1, `imem_req`<=0, go to ERR.
- EXEC:
  - Exactly 1 cycle. `instr0`/`instr1` are stable throughout, so the datapath performs its register write in this cycle.
  - Next-state priority:
    1. `instr0` op == `OP_END` -> HLT.
    2. `halt_req` -> HLT.
    3. Otherwise FETCH0.
  - `pc_load` in EXEC: `pc`<=`pc_load_val`, taking precedence over the prior increment. It is also applied when going to HLT.
  - `pc_load` outside EXEC is ignored.
- ERR:
  - Waits for `start`, which behaves as in HLT (clears `bus_err`).
  - `halt_req` in ERR -> HLT; `bus_err` stays set.
- Minimum instruction time, zero-latency ack:
  - 1-word instruction: 2 cycles (FETCH0, EXEC).
  - 2-word instruction: 3 cycles.
- `halt_req` asserted during FETCH does not abort the fetch; it takes effect at the end of EXEC.
- `instr0`/`instr1` keep their last values in HLT and ERR.

Test Plan:
- Sequential run, ack latency 0:
  - Stimulus: `start_pc`=0x0010; memory[0x10..0x12] = 0x02040005, 0x03080000, 0xDEADBEEF; memory[0x13] = 0xFF000000.
  - Required: states 1,3,1,2,3,1,3 then HLT.
  - `instr1`=0xDEADBEEF during the second EXEC; final `pc`=0x0014; `busy` falls after the END EXEC.
- Ack latency 5 cycles on every read:
  - Required: `imem_req`/`imem_addr` held stable for all 5 cycles.
  - Each instruction takes 7 cycles (1-word) or 13 cycles (LIMM32).
- Redirect:
  - Stimulus: `pc_load`=1, `pc_load_val`=0x0040 during the EXEC of the instruction at 0x10.
  - Required: the next `imem_addr` is 0x0040; `pc_load` pulsed in FETCH0 has no effect.
- `halt_req` raised mid-FETCH1:
  - Required: FETCH1 completes, EXEC occurs once, then HLT with `pc` pointing past the immediate.
- Timeout, `TIMEOUT`=8, `imem_ack` never asserted:
  - Required: ERR after 8 req cycles; `bus_err`=1, `imem_req`=0.
  - A subsequent `start` clears `bus_err` and refetches.
- Async reset 2 cycles into a pending FETCH0:
  - Required: all outputs return to 0/HLT immediately; a stray ack in the following cycle changes nothing.
- Wrap-around:
  - Stimulus: `PC_W`=4, `start_pc`=0xF, 1-word non-END instruction.
  - Required: `pc`=0x0 after its fetch.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: fetches 1- or 2-word instructions over a req/ack
// bus and sequences HLT -> FETCH0 -> (FETCH1) -> EXEC for the datapath.
module instr_fetch_seq #(
  parameter int         PC_W      = 16,
  parameter logic [7:0] OP_LIMM32 = 8'h03,
  parameter logic [7:0] OP_END    = 8'hFF,
  parameter int         TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            halt_req,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instr0,
  output logic [31:0]     instr1,
  output logic [3:0]      current_state,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            bus_err
);

  typedef enum logic [3:0] {
    S_HLT    = 4'd0,
    S_FETCH0 = 4'd1,
    S_FETCH1 = 4'd2,
    S_EXEC   = 4'd3,
    S_ERR    = 4'd4
  } state_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [7:0]      tcnt;
  logic            fetching, acc, tout, restart, launch, is_limm;
  logic [PC_W-1:0] launch_pc, pc_inc;

  assign fetching      = (state == S_FETCH0) || (state == S_FETCH1);
  assign acc           = fetching && imem_ack;
  assign tout          = fetching && !imem_ack && (tcnt == TLIM);
  assign restart       = ((state == S_HLT) || (state == S_ERR)) && start;
  assign is_limm       = (imem_data[31:24] == OP_LIMM32);
  assign pc_inc        = pc + 1'b1;
  assign current_state = state;
  assign busy          = (state != S_HLT);

  // launch: a new request is raised so it is already on the bus in the first
  // cycle of the following FETCH state.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    launch_pc = pc;
    case (state)
      S_HLT, S_ERR: begin
        if (start) begin
          state_nxt = S_FETCH0;
          launch    = 1'b1;
          launch_pc = start_pc;
        end else if (state == S_ERR && halt_req) begin
          state_nxt = S_HLT;
        end
      end
      S_FETCH0: begin
        if (imem_ack) begin
          if (is_limm) begin
            state_nxt = S_FETCH1;
            launch    = 1'b1;
            launch_pc = pc_inc;
          end else begin
            state_nxt = S_EXEC;
          end
        end else if (tout) begin
          state_nxt = S_ERR;
        end
      end
      S_FETCH1: begin
        if (imem_ack)  state_nxt = S_EXEC;
        else if (tout) state_nxt = S_ERR;
      end
      S_EXEC: begin
        launch_pc = pc_load ? pc_load_val : pc;
        if (instr0[31:24] == OP_END || halt_req) begin
          state_nxt = S_HLT;
        end else begin
          state_nxt = S_FETCH0;
          launch    = 1'b1;
        end
      end
      default: state_nxt = S_HLT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HLT;
      pc        <= '0;
      instr0    <= '0;
      instr1    <= '0;
      imem_addr <= '0;
      imem_req  <= 1'b0;
      bus_err   <= 1'b0;
      tcnt      <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        imem_req  <= 1'b1;
        imem_addr <= launch_pc;
      end else if (acc || tout) begin
        imem_req  <= 1'b0;
      end
      tcnt <= (fetching && !acc && !tout) ? tcnt + 8'd1 : 8'd0;
      if (tout)         bus_err <= 1'b1;
      else if (restart) bus_err <= 1'b0;
      if (restart)                    pc <= start_pc;
      else if (acc)                   pc <= pc_inc;
      else if (state == S_EXEC && pc_load) pc <= pc_load_val;
      if (acc && state == S_FETCH0) begin
        instr0 <= imem_data;
        if (!is_limm) instr1 <= '0;
      end
      if (acc && state == S_FETCH1) instr1 <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: a cycle-level reference model plus
// literal expectations for each scenario.
module tb_instr_fetch_seq;
  localparam int TO = 8;

  logic        clk = 0, reset = 1, start = 0, halt_req = 0, pc_load = 0;
  logic [15:0] start_pc = 0, pc_load_val = 0;
  logic        imem_req, busy, bus_err, imem_ack;
  logic [15:0] imem_addr, pc;
  logic [31:0] imem_data, instr0, instr1;
  logic [3:0]  current_state;

  logic        mem_ack = 0, stray_ack = 0;
  logic [31:0] mem_data = 0, stray_data = 0;
  assign imem_ack  = mem_ack | stray_ack;
  assign imem_data = stray_ack ? stray_data : mem_data;

  // narrow-PC instance for the wrap-around case
  logic       start4 = 0, ack4 = 0, halt4 = 0;
  logic [3:0] spc4 = 0, addr4, pc4, st4;
  logic [31:0] data4 = 0, i0_4, i1_4;
  logic       req4, busy4, err4;

  instr_fetch_seq #(.PC_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .halt_req(halt_req), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr0(instr0), .instr1(instr1),
    .current_state(current_state), .pc(pc), .busy(busy), .bus_err(bus_err));

  instr_fetch_seq #(.PC_W(4), .TIMEOUT(TO)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .start_pc(spc4),
    .halt_req(halt4), .pc_load(1'b0), .pc_load_val(4'h0),
    .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4),
    .imem_data(data4), .instr0(i0_4), .instr1(i1_4),
    .current_state(st4), .pc(pc4), .busy(busy4), .bus_err(err4));

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // memory: acks `lat` cycles after a request is seen
  logic [31:0] mem [0:255];
  int  lat = 0, wcnt = 0;
  bit  mem_en = 1;
  initial forever begin
    @(negedge clk);
    if (mem_en && imem_req) begin
      if (wcnt >= lat) begin
        mem_ack = 1; mem_data = mem[imem_addr[7:0]]; wcnt = 0;
      end else begin
        mem_ack = 0; wcnt++;
      end
    end else begin
      mem_ack = 0; wcnt = 0;
    end
  end

  // reference model, advanced once per clock from the bench-driven inputs
  int          m_st, m_tc;
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_i0, m_i1;
  logic        m_req, m_err;
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_st = 0; m_tc = 0; m_pc = 0; m_addr = 0; m_i0 = 0; m_i1 = 0; m_req = 0; m_err = 0;
    end else if (m_st == 0 || m_st == 4) begin
      if (start) begin
        m_pc = start_pc; m_err = 0; m_req = 1; m_addr = start_pc; m_tc = 0; m_st = 1;
      end else if (m_st == 4 && halt_req) m_st = 0;
    end else if (m_st == 1 || m_st == 2) begin
      if (imem_ack) begin
        if (m_st == 1) m_i0 = imem_data;
        m_pc = m_pc + 16'd1; m_tc = 0;
        if (m_st == 1 && imem_data[31:24] == 8'h03) begin
          m_st = 2; m_addr = m_pc;
        end else begin
          m_i1 = (m_st == 1) ? 32'h0 : imem_data; m_req = 0; m_st = 3;
        end
      end else begin
        m_tc++;
        if (m_tc == TO) begin m_err = 1; m_req = 0; m_st = 4; m_tc = 0; end
      end
    end else begin
      if (pc_load) m_pc = pc_load_val;
      if (m_i0[31:24] == 8'hFF || halt_req) m_st = 0;
      else begin m_st = 1; m_req = 1; m_addr = m_pc; m_tc = 0; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("state", current_state, 64'(m_st));
      chk("pc", pc, m_pc);
      chk("instr0", instr0, m_i0);
      chk("instr1", instr1, m_i1);
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, m_addr);
      chk("busy", busy, m_st != 0);
      chk("bus_err", bus_err, m_err);
    end
  end

  task automatic pulse_start(input logic [15:0] a);
    @(negedge clk); start = 1; start_pc = a;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int maxc, input string nm);
    int n = 0;
    while (current_state !== s && n < maxc) begin @(negedge clk); n++; end
    chk(nm, current_state, s);
  endtask

  logic [3:0]  tr [8];
  logic [3:0]  exp_tr [8] = '{1, 3, 1, 2, 3, 1, 3, 0};
  logic [31:0] i1v;
  logic        busy7;
  int          n, exec_pos[$], hold;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_state", current_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);

    // sequential run, zero latency
    mem[8'h10] = 32'h02040005; mem[8'h11] = 32'h03080000;
    mem[8'h12] = 32'hDEADBEEF; mem[8'h13] = 32'hFF000000;
    pulse_start(16'h0010);
    for (int i = 0; i < 8; i++) begin
      tr[i] = current_state;
      if (i == 4) i1v = instr1;
      if (i == 7) busy7 = busy;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("seq_state%0d", i), tr[i], exp_tr[i]);
    chk("seq_instr1", i1v, 32'hDEADBEEF);
    chk("seq_pc", pc, 16'h0014);
    chk("seq_busy_end", busy7, 0);

    // ack latency 5
    lat = 5;
    pulse_start(16'h0010);
    n = 0; hold = 0;
    while (current_state != 0 && n < 100) begin
      if (current_state == 3) exec_pos.push_back(n);
      if (exec_pos.size() == 0 && imem_req && imem_addr == 16'h0010) hold++;
      @(negedge clk); n++;
    end
    chk("lat_cycles", n, 27);
    chk("lat_nexec", exec_pos.size(), 3);
    if (exec_pos.size() == 3) begin
      chk("lat_exec0", exec_pos[0], 6);
      chk("lat_exec1", exec_pos[1], 19);
      chk("lat_exec2", exec_pos[2], 26);
    end
    chk("lat_hold", hold, 6);

    // redirect in EXEC, ignored in FETCH0
    lat = 0;
    mem[8'h40] = 32'hFF000000;
    mem[8'h11] = 32'h01000000;
    pulse_start(16'h0010);
    pc_load = 1; pc_load_val = 16'h0080;
    @(negedge clk);
    chk("redir_exec", current_state, 3);
    chk("redir_ign", pc, 16'h0011);
    pc_load_val = 16'h0040;
    @(negedge clk);
    pc_load = 0;
    chk("redir_addr", imem_addr, 16'h0040);
    repeat (2) @(negedge clk);
    chk("redir_hlt", current_state, 0);
    chk("redir_pc", pc, 16'h0041);

    // halt_req during FETCH1
    lat = 3;
    mem[8'h20] = 32'h03000000; mem[8'h21] = 32'h12345678; mem[8'h22] = 32'h01000000;
    pulse_start(16'h0020);
    wait_state(2, 30, "halt_f1");
    halt_req = 1;
    wait_state(3, 30, "halt_exec");
    @(negedge clk);
    halt_req = 0;
    chk("halt_state", current_state, 0);
    chk("halt_pc", pc, 16'h0022);
    chk("halt_imm", instr1, 32'h12345678);

    // timeout, then halt from ERR, then restart
    mem_en = 0;
    pulse_start(16'h0030);
    n = 0;
    while (current_state == 1 && n < 20) begin @(negedge clk); n++; end
    chk("to_cycles", n, TO);
    chk("to_state", current_state, 4);
    chk("to_err", bus_err, 1);
    chk("to_req", imem_req, 0);
    halt_req = 1;
    @(negedge clk);
    halt_req = 0;
    chk("err_halt", current_state, 0);
    chk("err_sticky", bus_err, 1);
    mem_en = 1; lat = 0;
    mem[8'h30] = 32'hFF000000;
    pulse_start(16'h0030);
    chk("to_clr", bus_err, 0);
    chk("to_refetch", imem_addr, 16'h0030);
    wait_state(0, 10, "to_end");

    // async reset during pending fetch, then stray ack
    lat = 5;
    pulse_start(16'h0010);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("ar_state", current_state, 0);
    chk("ar_req", imem_req, 0);
    chk("ar_pc", pc, 0);
    chk("ar_instr0", instr0, 0);
    chk("ar_addr", imem_addr, 0);
    @(negedge clk);
    reset = 0; stray_ack = 1; stray_data = 32'h03000000;
    @(negedge clk);
    stray_ack = 0;
    chk("stray_state", current_state, 0);
    chk("stray_instr0", instr0, 0);
    chk("stray_pc", pc, 0);

    // 4-bit PC wrap
    @(negedge clk); start4 = 1; spc4 = 4'hF;
    @(negedge clk); start4 = 0;
    chk("w_addr", addr4, 4'hF);
    chk("w_req", req4, 1);
    ack4 = 1; data4 = 32'h01000000; halt4 = 1;
    @(negedge clk);
    ack4 = 0;
    chk("w_pc", pc4, 4'h0);
    chk("w_exec", st4, 3);
    chk("w_instr0", i0_4, 32'h01000000);
    chk("w_instr1", i1_4, 0);
    @(negedge clk);
    chk("w_hlt", st4, 0);
    chk("w_busy", busy4, 0);
    chk("w_err", err4, 0);
    halt4 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
